// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder-tree loader and its occupancy counter.
package adder_tree_pkg;

    // Loader phases: collect terms, then launch the assembled vector for one cycle.
    typedef enum logic {
        LOAD = 1'b0,
        FIRE = 1'b1
    } loader_state_e;

    // Bit offset of slot k inside the packed tree vector.
    function automatic int unsigned slot_offset(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/adder_tree_loader_inflight_counter.sv
// Saturating up/down occupancy counter; flags a decrement requested while empty.
module inflight_counter #(
    parameter int MAX   = 8,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             underflow_pulse
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

    // Simultaneous inc/dec cancel; the count is clamped to [0, MAX].
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (inc && !dec && (count < MAX_CNT)) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign full            = (count == MAX_CNT);
    assign underflow_pulse = dec && (count == '0);

endmodule

// File: rtl/adder_tree_loader.sv
// Serial-to-parallel loader: packs a stream of terms into a zero-padded vector,
// launches it into the adder tree with a one-cycle start and tracks occupancy.
module adder_tree_loader
    import adder_tree_pkg::*;
#(
    parameter int INPUTS_NUM   = 125,
    parameter int IDATA_WIDTH  = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int IDX_WIDTH    = $clog2(INPUTS_NUM),
    parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [IDATA_WIDTH-1:0]            s_data,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [INPUTS_NUM*IDATA_WIDTH-1:0] tree_idata,
    output logic                              tree_start,
    input  logic                              tree_done,
    output logic [CNT_WIDTH-1:0]              inflight,
    output logic                              idle,
    output logic                              err_underflow
);

    localparam int                   VEC_W    = INPUTS_NUM * IDATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(INPUTS_NUM - 1);

    loader_state_e        state;
    loader_state_e        state_nxt;
    logic [IDX_WIDTH-1:0] idx;
    logic [VEC_W-1:0]     buffer;
    logic                 accept;
    logic                 last_word;
    logic                 full;
    logic                 underflow_pulse;

    // Next-state and handshake decode; FIRE always lasts exactly one cycle.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        tree_start = 1'b0;
        accept     = 1'b0;
        last_word  = s_last || (idx == LAST_IDX);
        unique case (state)
            LOAD: begin
                s_ready = !full;
                accept  = s_valid && !full;
                if (accept && last_word) begin
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                tree_start = 1'b1;
                state_nxt  = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot index: holds on the completing word so FIRE sees the finished vector.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx <= '0;
        end else if (state == FIRE) begin
            idx <= '0;
        end else if (accept && !last_word) begin
            idx <= idx + IDX_WIDTH'(1);
        end
    end

    // Vector buffer: written slot by slot, cleared after launch so short vectors zero-pad.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buffer <= '0;
        end else if (state == FIRE) begin
            buffer <= '0;
        end else if (accept) begin
            for (int k = 0; k < INPUTS_NUM; k++) begin
                if (idx == IDX_WIDTH'(k)) begin
                    buffer[slot_offset(k, IDATA_WIDTH) +: IDATA_WIDTH] <= s_data;
                end
            end
        end
    end

    // Sticky flag for a tree result arriving with nothing in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_underflow <= 1'b0;
        end else if (underflow_pulse) begin
            err_underflow <= 1'b1;
        end
    end

    inflight_counter #(
        .MAX   (MAX_INFLIGHT),
        .WIDTH (CNT_WIDTH)
    ) u_inflight (
        .clk             (clk),
        .nrst            (nrst),
        .inc             (tree_start),
        .dec             (tree_done),
        .count           (inflight),
        .full            (full),
        .underflow_pulse (underflow_pulse)
    );

    assign tree_idata = buffer;
    assign idle       = (state == LOAD) && (idx == '0) && (inflight == '0);

endmodule

// File: tb/tb_adder_tree_loader.sv
// Self-checking bench for adder_tree_loader (4 x 8-bit terms, up to 2 in flight).
module tb_adder_tree_loader;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MAX = 2;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          nrst;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [N*W-1:0] tree_idata;
    logic          tree_start;
    logic          tree_done;
    logic [CW-1:0] inflight;
    logic          idle;
    logic          err_underflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words of the vector being collected, a completed vector
    // awaiting launch, the number of vectors in the tree and the error flag.
    logic [W-1:0]   m_words[$];
    bit             m_fire;
    logic [N*W-1:0] m_vec;
    int             m_inflight;
    bit             m_err;

    adder_tree_loader #(
        .INPUTS_NUM   (N),
        .IDATA_WIDTH  (W),
        .MAX_INFLIGHT (MAX)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .tree_idata    (tree_idata),
        .tree_start    (tree_start),
        .tree_done     (tree_done),
        .inflight      (inflight),
        .idle          (idle),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        return !m_fire && (m_inflight < MAX);
    endfunction

    function automatic bit exp_idle();
        return !m_fire && (m_words.size() == 0) && (m_inflight == 0);
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_fire     = 0;
        m_vec      = '0;
        m_inflight = 0;
        m_err      = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        bit acc;
        bit launched;
        acc      = s_valid && exp_ready();
        launched = m_fire;
        if (!nrst) begin
            model_reset();
            return;
        end
        if (m_fire) begin
            m_fire = 0;
            m_words.delete();
        end else if (acc) begin
            m_words.push_back(s_data);
            if (s_last || m_words.size() == N) begin
                m_fire = 1;
                m_vec  = '0;
                foreach (m_words[i]) m_vec[i*W +: W] = m_words[i];
            end
        end
        if (tree_done && m_inflight == 0) m_err = 1;
        if (launched && !tree_done) m_inflight++;
        else if (tree_done && !launched && m_inflight > 0) m_inflight--;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit l, input bit done);
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        tree_done = done;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0);
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", idle); end
        n_cmp++; if (tree_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b expected 0", tree_start); end
        n_cmp++; if (inflight !== '0) begin n_err++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        n_cmp++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_underflow); end
        n_cmp++; if (tree_idata !== '0) begin n_err++; $display("FAIL reset_idata: got %h expected 0", tree_idata); end
    endtask

    task automatic test_full_vector();
        logic [W-1:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tree_start !== 1'b0) begin n_err++; $display("FAIL full_early_start: cycle %0d got 1 expected 0", i + 1); end
            drive(1, words[i], 0, 0);
            tick();
        end
        drive(0, '0, 0, 0);
        n_cmp++; if (tree_start !== 1'b1) begin n_err++; $display("FAIL full_start: got %b expected 1", tree_start); end
        n_cmp++; if (tree_idata !== 32'h44332211) begin n_err++; $display("FAIL full_idata: got %h expected 44332211", tree_idata); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_fire: got %b expected 0", s_ready); end
        tick();
        n_cmp++; if (inflight !== CW'(1)) begin n_err++; $display("FAIL full_inflight: got %0d expected 1", inflight); end
        n_cmp++; if (tree_start !== 1'b0) begin n_err++; $display("FAIL full_start_len: got %b expected 0", tree_start); end
        drive(0, '0, 0, 1);
        tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (inflight !== '0 || idle !== 1'b1) begin n_err++; $display("FAIL full_drain: got inflight %0d idle %b expected 0 1", inflight, idle); end
    endtask

    task automatic test_short_vector();
        drive(1, 8'hAA, 0, 0); tick();
        drive(1, 8'hBB, 1, 0); tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (tree_start !== 1'b1 || tree_idata !== 32'h0000BBAA) begin n_err++; $display("FAIL short_idata: got start %b data %h expected 1 0000bbaa", tree_start, tree_idata); end
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1, W'(i), 0, 0); tick();
        end
        drive(0, '0, 0, 0);
        n_cmp++; if (tree_start !== 1'b1 || tree_idata !== 32'h04030201) begin n_err++; $display("FAIL short_next_full: got start %b data %h expected 1 04030201", tree_start, tree_idata); end
        tick();
        n_cmp++; if (inflight !== CW'(2)) begin n_err++; $display("FAIL short_inflight: got %0d expected 2", inflight); end
        drive(0, '0, 0, 1); tick(); tick();
        drive(0, '0, 0, 0);
    endtask

    task automatic test_backpressure();
        drive(1, 8'h01, 1, 0); tick();
        drive(0, '0, 0, 0);    tick();
        drive(1, 8'h02, 1, 0); tick();
        drive(0, '0, 0, 0);    tick();
        n_cmp++; if (inflight !== CW'(2) || s_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got inflight %0d ready %b expected 2 0", inflight, s_ready); end
        drive(1, 8'h55, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (idle !== 1'b0 || s_ready !== 1'b0 || tree_start !== 1'b0) begin n_err++; $display("FAIL bp_hold: got idle %b ready %b start %b expected 0 0 0", idle, s_ready, tree_start); end
        drive(1, 8'h77, 1, 1); tick();
        drive(1, 8'h77, 1, 0);
        n_cmp++; if (inflight !== CW'(1) || s_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got inflight %0d ready %b expected 1 1", inflight, s_ready); end
        tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (tree_start !== 1'b1 || tree_idata !== 32'h00000077) begin n_err++; $display("FAIL bp_data: got start %b data %h expected 1 00000077", tree_start, tree_idata); end
        tick();
        drive(0, '0, 0, 1); tick(); tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (inflight !== '0) begin n_err++; $display("FAIL bp_drain: got %0d expected 0", inflight); end
    endtask

    task automatic test_simultaneous();
        drive(1, 8'h10, 1, 0); tick();
        drive(0, '0, 0, 0);    tick();
        drive(1, 8'h20, 1, 0); tick();
        drive(0, '0, 0, 1);
        n_cmp++; if (tree_start !== 1'b1 || inflight !== CW'(1)) begin n_err++; $display("FAIL simul_pre: got start %b inflight %0d expected 1 1", tree_start, inflight); end
        tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (inflight !== CW'(1)) begin n_err++; $display("FAIL simul_count: got %0d expected 1", inflight); end
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 0, 0);
    endtask

    task automatic test_underflow();
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (err_underflow !== 1'b1 || inflight !== '0) begin n_err++; $display("FAIL uf_set: got err %b inflight %0d expected 1 0", err_underflow, inflight); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b expected 1", err_underflow); end
    endtask

    task automatic test_async_reset();
        drive(1, 8'hE1, 0, 0); tick();
        drive(1, 8'hE2, 0, 0); tick();
        drive(0, '0, 0, 0);
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL ar_partial: got idle %b expected 0", idle); end
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++; if (idle !== 1'b1 || err_underflow !== 1'b0 || tree_idata !== '0 || s_ready !== 1'b1) begin n_err++; $display("FAIL ar_immediate: got idle %b err %b data %h ready %b expected 1 0 0 1", idle, err_underflow, tree_idata, s_ready); end
        tick();
        nrst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, W'(i), 0, 0); tick();
        end
        drive(0, '0, 0, 0);
        n_cmp++; if (tree_start !== 1'b1 || tree_idata !== 32'h04030201) begin n_err++; $display("FAIL ar_after: got start %b data %h expected 1 04030201", tree_start, tree_idata); end
        tick();
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 4) == 0,
                  (m_inflight > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 60) == 0));
            n_cmp++; if (s_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", c, s_ready, exp_ready()); end
            n_cmp++; if (tree_start !== m_fire) begin n_err++; $display("FAIL rnd_start: cycle %0d got %b expected %b", c, tree_start, m_fire); end
            n_cmp++; if (inflight !== CW'(m_inflight)) begin n_err++; $display("FAIL rnd_inflight: cycle %0d got %0d expected %0d", c, inflight, m_inflight); end
            n_cmp++; if (idle !== exp_idle()) begin n_err++; $display("FAIL rnd_idle: cycle %0d got %b expected %b", c, idle, exp_idle()); end
            n_cmp++; if (err_underflow !== m_err) begin n_err++; $display("FAIL rnd_err: cycle %0d got %b expected %b", c, err_underflow, m_err); end
            if (m_fire) begin
                n_cmp++; if (tree_idata !== m_vec) begin n_err++; $display("FAIL rnd_idata: cycle %0d got %h expected %h", c, tree_idata, m_vec); end
            end
            tick();
        end
        drive(0, '0, 0, 0);
    endtask

    initial begin
        nrst = 1'b0;
        drive(0, '0, 0, 0);
        model_reset();
        #1;
        test_reset();
        test_full_vector();
        test_short_vector();
        test_backpressure();
        test_simultaneous();
        test_underflow();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
